// File: rtl/combo_code_driver.sv
// Combination-lock initiator: holds a DIGITS-long code, plays it into a lock
// digit by digit after a clear pulse, then reports whether the lock opened.
module combo_code_driver #(
    parameter int          DIGITS    = 4,
    parameter int          HOLD      = 4,
    parameter int          GAP       = 2,
    parameter logic [3:0]  IDLE_CODE = 4'h0,
    parameter int          TIMEOUT   = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       start,
    input  logic       lock_open,
    output logic [3:0] code_out,
    output logic       lock_clr,
    output logic       busy,
    output logic       pass,
    output logic       fail
);

    localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
    localparam int MAXC  = (MAXHG > TIMEOUT) ? MAXHG : TIMEOUT;
    localparam int CW    = $clog2(MAXC + 1);
    localparam int IW    = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRIVE,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0][3:0] store_q, store_d;
    logic [3:0]             code_q, code_d, sel_digit;
    logic                   clr_q, clr_d;
    logic                   busy_q, busy_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;

    // Newest digit enters at the tail so position 0 holds the oldest of the last DIGITS loads.
    always_comb begin
        store_d = store_q;
        if (state_q == S_IDLE && load) begin
            for (int i = 0; i < DIGITS - 1; i++) begin
                store_d[i] = store_q[i+1];
            end
            store_d[DIGITS-1] = load_digit;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_DRIVE;
                cnt_d   = '0;
                idx_d   = '0;
            end
            S_DRIVE: begin
                if (int'(cnt_q) == HOLD - 1) begin
                    cnt_d = '0;
                    if (int'(idx_q) == DIGITS - 1) begin
                        state_d = S_WAIT;
                    end else if (GAP == 0) begin
                        idx_d = idx_q + IW'(1);
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (int'(cnt_q) == GAP - 1) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                    idx_d   = idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (lock_open) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    pass_d  = 1'b1;
                end else if (int'(cnt_q) == TIMEOUT - 1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    fail_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next state so they line up with the registered state.
    always_comb begin
        sel_digit = IDLE_CODE;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(idx_d) == i) sel_digit = store_q[i];
        end
        code_d = (state_d == S_DRIVE) ? sel_digit : IDLE_CODE;
        clr_d  = (state_d == S_CLEAR);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            store_q <= {DIGITS{IDLE_CODE}};
            code_q  <= IDLE_CODE;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            store_q <= store_d;
            code_q  <= code_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign code_out = code_q;
    assign lock_clr = clr_q;
    assign busy     = busy_q;
    assign pass     = pass_q;
    assign fail     = fail_q;

endmodule
